// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory command port between icache and dcache miss engines; dcache priority, icache starve-bounded.
// Latency: grant in 1 IDLE cycle, command next cycle, read beats forwarded 1 cycle after mem_rvalid, done 1 cycle after last beat/write handshake.
// Backpressure: command held stable on mem_valid until mem_ready; requesters hold req until their done pulse, CPU stalled meanwhile.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rvalid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_rvalid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              err
);

  localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [BEAT_W-1:0]   BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                owner_ic_q, owner_ic_d;
  logic                rnw_q, rnw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ic_rvalid_q, ic_rvalid_d;
  logic                dc_rvalid_q, dc_rvalid_d;
  logic [DATA_W-1:0]   ic_rdata_q, ic_rdata_d;
  logic [DATA_W-1:0]   dc_rdata_q, dc_rdata_d;
  logic                err_q, err_d;

  logic any_req;
  logic grant_ic;
  logic owner_req;

  // icache wins when alone, or when dcache has already won STARVE_MAX contended rounds
  assign any_req   = ic_req | dc_req;
  assign grant_ic  = ic_req & (~dc_req | (starve_q == STARVE_LIM));
  assign owner_req = owner_ic_q ? ic_req : dc_req;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_ISSUE;
      S_ISSUE:  if (mem_ready) state_d = rnw_q ? S_RDWAIT : S_DONE;
      S_RDWAIT: if (mem_rvalid && (beat_q == BEAT_LAST)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // state-decoded outputs: command valid and the owner's completion pulse
  always_comb begin
    mem_valid = 1'b0;
    ic_done   = 1'b0;
    dc_done   = 1'b0;
    case (state_q)
      S_ISSUE: mem_valid = 1'b1;
      S_DONE: begin
        ic_done = owner_ic_q;
        dc_done = ~owner_ic_q;
      end
      default: ;
    endcase
  end

  // command latch, starvation count, beat count, read return path and error tracking
  always_comb begin
    starve_d    = starve_q;
    beat_d      = beat_q;
    owner_ic_d  = owner_ic_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ic_rvalid_d = 1'b0;
    dc_rvalid_d = 1'b0;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    err_d       = err_q;

    if (state_q == S_IDLE && any_req) begin
      owner_ic_d = grant_ic;
      if (grant_ic) begin
        rnw_d    = 1'b1;
        addr_d   = ic_addr;
        wdata_d  = '0;
        starve_d = '0;
      end else begin
        rnw_d   = ~dc_we;
        addr_d  = dc_addr;
        wdata_d = dc_wdata;
        // only a contended dcache win counts toward icache starvation
        if (ic_req) starve_d = starve_q + STARVE_W'(1);
      end
    end

    if (state_q == S_ISSUE && mem_ready && rnw_q) begin
      beat_d = '0;
    end

    if (state_q == S_RDWAIT && mem_rvalid) begin
      beat_d = beat_q + BEAT_W'(1);
      if (owner_ic_q) begin
        ic_rdata_d  = mem_rdata;
        ic_rvalid_d = 1'b1;
      end else begin
        dc_rdata_d  = mem_rdata;
        dc_rvalid_d = 1'b1;
      end
    end

    // stray read beats, or the owner dropping req mid-command, are protocol errors
    if (mem_rvalid && state_q != S_RDWAIT) err_d = 1'b1;
    if ((state_q == S_ISSUE || state_q == S_RDWAIT) && !owner_req) err_d = 1'b1;
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q    <= '0;
      beat_q      <= '0;
      owner_ic_q  <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      beat_q      <= beat_d;
      owner_ic_q  <= owner_ic_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ic_rvalid_q <= ic_rvalid_d;
      dc_rvalid_q <= dc_rvalid_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_rnw   = rnw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ic_rvalid = ic_rvalid_q;
  assign dc_rvalid = dc_rvalid_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign err       = err_q;
  assign stall     = ic_req | dc_req;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed bench for mem_port_arbiter with a read-beat scoreboard.
// Latency: expects read beats one cycle after mem_rvalid and done with the last beat.
// Backpressure: bench plays the memory, holding or releasing mem_ready per step.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_rvalid;
  logic [31:0] ic_rdata;
  logic        ic_done;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic        dc_rvalid;
  logic [31:0] dc_rdata;
  logic        dc_done;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_rnw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        err;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .BURST_LEN(4), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          own_ic;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   rv_cyc_q[$];
  int   done_cyc_q[$];
  bit   done_own_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // read-return monitor: every rvalid must match the oldest expected beat
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (ic_rvalid || dc_rvalid) begin
        rv_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", {ic_rvalid, dc_rvalid}, 2'b00);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rvalid_owner", {ic_rvalid, dc_rvalid}, e.own_ic ? 2'b10 : 2'b01);
          chk("rdata", e.own_ic ? ic_rdata : dc_rdata, e.data);
        end
      end
      if (ic_done || dc_done) begin
        chk("done_onehot", {ic_done, dc_done} == 2'b11, 1'b0);
        done_own_q.push_back(ic_done);
        done_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit own_ic, input logic [31:0] d, input bit expected);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    if (expected) exp_q.push_back('{own_ic, d});
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic wait_cmd();
    for (int i = 0; i < 20 && !mem_valid; i++) tick();
    chk("cmd_wait", mem_valid, 1'b1);
  endtask

  task automatic do_read(input bit own_ic, input logic [31:0] addr, input logic [31:0] d0);
    if (own_ic) begin
      ic_req = 1'b1; ic_addr = addr;
    end else begin
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = addr;
    end
    mem_ready = 1'b1;
    wait_cmd();
    chk("rd_rnw", mem_rnw, 1'b1);
    chk("rd_addr", mem_addr, addr);
    tick();
    for (int b = 0; b < 4; b++) beat(own_ic, d0 + 32'(b), 1'b1);
    chk("rd_done", own_ic ? ic_done : dc_done, 1'b1);
    chk("rd_last_data", own_ic ? ic_rdata : dc_rdata, d0 + 32'd3);
    ic_req = 1'b0;
    dc_req = 1'b0;
    tick();
  endtask

  bit exp_ic_order [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int base;
  int rv_rel [4] = '{1, 3, 4, 8};

  initial begin
    rst = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) tick();

    // reset state
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_outs", {ic_rvalid, dc_rvalid, ic_done, dc_done, err, mem_rnw}, 6'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rdata", {ic_rdata, dc_rdata}, 64'h0);
    rst = 1'b1;
    tick();

    // single icache read, immediate ready, back-to-back beats
    ic_req = 1'b1; ic_addr = 32'h100; mem_ready = 1'b1;
    tick();
    chk("ic_cmd_valid", mem_valid, 1'b1);
    chk("ic_cmd_rnw", mem_rnw, 1'b1);
    chk("ic_cmd_addr", mem_addr, 32'h100);
    chk("ic_stall", stall, 1'b1);
    tick();
    chk("ic_cmd_one_cycle", mem_valid, 1'b0);
    for (int b = 0; b < 4; b++) beat(1'b1, 32'hA0 + 32'(b), 1'b1);
    chk("ic_done_with_last", {ic_done, ic_rvalid, dc_done}, 3'b110);
    chk("ic_last_data", ic_rdata, 32'hA3);
    ic_req = 1'b0;
    tick();
    chk("ic_done_pulse", ic_done, 1'b0);
    chk("ic_stall_drop", stall, 1'b0);

    // dcache write with mem_ready low for 3 cycles
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h200; dc_wdata = 32'hDEADBEEF; mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wr_valid", mem_valid, 1'b1);
      chk("wr_rnw", mem_rnw, 1'b0);
      chk("wr_addr", mem_addr, 32'h200);
      chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
      chk("wr_stall", stall, 1'b1);
      chk("wr_no_done", dc_done, 1'b0);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    chk("wr_done", {dc_done, mem_valid, stall}, 3'b101);
    dc_req = 1'b0;
    tick();
    chk("wr_done_pulse", dc_done, 1'b0);
    chk("wr_stall_drop", stall, 1'b0);

    // dcache read with gaps between beats
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h240;
    wait_cmd();
    tick();
    rv_cyc_q.delete();
    done_cyc_q.delete();
    base = cyc;
    beat(1'b0, 32'hD0, 1'b1);
    tick();
    beat(1'b0, 32'hD1, 1'b1);
    beat(1'b0, 32'hD2, 1'b1);
    repeat (3) tick();
    beat(1'b0, 32'hD3, 1'b1);
    chk("gap_done", dc_done, 1'b1);
    dc_req = 1'b0;
    tick();
    chk("gap_rv_count", rv_cyc_q.size(), 4);
    for (int i = 0; i < 4 && i < rv_cyc_q.size(); i++) chk("gap_rv_cycle", rv_cyc_q[i] - base, rv_rel[i]);
    chk("gap_done_count", done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0) chk("gap_done_cycle", done_cyc_q[0] - base, 8);

    // stray beat while idle sets sticky err
    chk("err_before", err, 1'b0);
    beat(1'b0, 32'h55, 1'b0);
    chk("err_set", err, 1'b1);
    chk("err_no_outs", {ic_rvalid, dc_rvalid, ic_done, dc_done}, 4'b0);
    repeat (2) tick();
    chk("err_sticky", err, 1'b1);
    do_read(1'b1, 32'h180, 32'hB0);
    chk("err_still", err, 1'b1);

    // async reset in the middle of a burst
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h500;
    wait_cmd();
    tick();
    beat(1'b0, 32'h11, 1'b1);
    beat(1'b0, 32'h22, 1'b1);
    rst = 1'b0;
    dc_req = 1'b0;
    #1;
    chk("arst_outs", {mem_valid, dc_rvalid, dc_done, ic_rvalid, ic_done, err, mem_rnw}, 7'b0);
    chk("arst_rdata", dc_rdata, 32'h0);
    chk("arst_addr", mem_addr, 32'h0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    do_read(1'b0, 32'h500, 32'hE0);
    chk("arst_err_clear", err, 1'b0);
    beat(1'b0, 32'h77, 1'b0);
    chk("late_beat_err", err, 1'b1);

    // both requesters held: bounded starvation grant order
    done_own_q.delete();
    ic_req = 1'b1; ic_addr = 32'h300;
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h400; dc_wdata = 32'h1234;
    mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_cmd();
      chk("grant_rnw", mem_rnw, exp_ic_order[k]);
      chk("grant_addr", mem_addr, exp_ic_order[k] ? 32'h300 : 32'h400);
      tick();
      if (exp_ic_order[k]) begin
        for (int b = 0; b < 4; b++) beat(1'b1, 32'hC0 + 32'(k * 4 + b), 1'b1);
      end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    tick();
    chk("grant_count", done_own_q.size(), 8);
    for (int k = 0; k < 8 && k < done_own_q.size(); k++) chk("grant_order", done_own_q[k], exp_ic_order[k]);

    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
